// File: rtl/host_dbg_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | host_dbg_sequencer_pkg                                                     |
// | Opcodes, FSM states and control-word bit positions for the debug sequencer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package host_dbg_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_CORE_RST = 3'd0,
        OP_STEP     = 3'd1,
        OP_ROM_WR   = 3'd2,
        OP_ROM_RD   = 3'd3,
        OP_RF_RD    = 3'd4,
        OP_PC_RD    = 3'd5,
        OP_CLKSEL   = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CRST   = 3'd1,
        SETUP  = 3'd2,
        WE     = 3'd3,
        SETTLE = 3'd4,
        CLK_HI = 3'd5,
        CLK_LO = 3'd6,
        RESP   = 3'd7
    } state_e;

    localparam int c_reg0_rst_bit  = 0;
    localparam int c_reg0_clk_bit  = 1;
    localparam int c_reg0_sel_bit  = 2;
    localparam int c_reg2_we_bit   = 0;
    localparam int c_reg2_addr_lsb = 1;
    localparam int c_reg2_sel_bit  = 7;

    function automatic logic is_read_op(input op_e op);
        return op inside {OP_ROM_RD, OP_RF_RD, OP_PC_RD};
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_dbg_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | host_dbg_phase_timer                                                       |
// | Loadable down-counter; done pulses on the last cycle of a timed phase      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module host_dbg_phase_timer (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] load,
    output logic        done
);

    logic [31:0] r_cnt;
    logic        r_busy;

    // A start on the same edge as done chains phases back to back.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_cnt  <= load;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == 32'd1) begin
                r_busy <= 1'b0;
            end
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign done = r_busy && (r_cnt == 32'd1);

endmodule
`default_nettype wire

// File: rtl/host_dbg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | host_dbg_sequencer                                                         |
// | Host debug command sequencer (reset, step, ROM/RF/PC access, clock select) |
// | Option macro: HOST_DBG_SEQ_MULTISTEP_EN (multi-step STEP command)          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module host_dbg_sequencer #(
    parameter int unsigned HOLD_CYC   = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned RST_CYC    = 8
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] ctrl_reg0,
    output logic [31:0] ctrl_reg1,
    output logic [31:0] ctrl_reg2,
    output logic [31:0] ctrl_reg3,
    output logic [31:0] ctrl_reg4,
    input  logic [31:0] stat_reg5,
    input  logic [31:0] stat_reg6,
    input  logic [31:0] stat_reg7
);
    import host_dbg_sequencer_pkg::*;

    state_e      r_state;
    op_e         r_op;
    logic        r_rst_host;
    logic        r_clk_host;
    logic        r_clk_select;
    logic [4:0]  r_rf_addr;
    logic        r_rom_select;
    logic [5:0]  r_rom_addr;
    logic        r_rom_we;
    logic [31:0] r_rom_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    op_e         w_cmd_op;
    logic        w_accept;
    logic        w_step_go;
    logic        w_last_step;
    logic        w_tmr_start;
    logic [31:0] w_tmr_load;
    logic        w_tmr_done;

    assign w_cmd_op = op_e'(cmd_op);
    assign w_accept = (r_state == IDLE) && cmd_valid;

`ifdef HOST_DBG_SEQ_MULTISTEP_EN
    logic [31:0] r_steps_left;
    assign w_step_go   = (cmd_data != 32'd0);
    assign w_last_step = (r_steps_left == 32'd1);
`else
    assign w_step_go   = 1'b1;
    assign w_last_step = 1'b1;
`endif

    always_comb begin
        w_tmr_start = 1'b0;
        w_tmr_load  = 32'(HOLD_CYC);
        case (r_state)
            IDLE: begin
                if (w_accept && (w_cmd_op == OP_CORE_RST)) begin
                    w_tmr_start = 1'b1;
                    w_tmr_load  = 32'(RST_CYC);
                end else if (w_accept && (w_cmd_op == OP_STEP) && w_step_go) begin
                    w_tmr_start = 1'b1;
                end
            end
            SETUP: begin
                if (is_read_op(r_op)) begin
                    w_tmr_start = 1'b1;
                    w_tmr_load  = 32'(SETTLE_CYC);
                end
            end
            CLK_HI:  w_tmr_start = w_tmr_done;
            CLK_LO:  w_tmr_start = w_tmr_done && !w_last_step;
            default: w_tmr_start = 1'b0;
        endcase
    end

    host_dbg_phase_timer u_phase_timer (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .start  (w_tmr_start),
        .load   (w_tmr_load),
        .done   (w_tmr_done)
    );

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op         <= OP_CORE_RST;
            r_rst_host   <= 1'b0;
            r_clk_host   <= 1'b0;
            r_clk_select <= 1'b0;
            r_rf_addr    <= '0;
            r_rom_select <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_we     <= 1'b0;
            r_rom_wdata  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
`ifdef HOST_DBG_SEQ_MULTISTEP_EN
            r_steps_left <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_cmd_op;
                        r_rsp_err <= (w_cmd_op == OP_RSVD);
                        case (w_cmd_op)
                            OP_CORE_RST: begin
                                r_rst_host <= 1'b1;
                                r_state    <= CRST;
                            end
                            OP_STEP: begin
                                if (w_step_go) begin
                                    r_clk_host <= 1'b1;
                                    r_state    <= CLK_HI;
`ifdef HOST_DBG_SEQ_MULTISTEP_EN
                                    r_steps_left <= cmd_data;
`endif
                                end else begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= stat_reg5;
                                    r_state     <= RESP;
                                end
                            end
                            OP_ROM_WR: begin
                                r_rom_select <= 1'b1;
                                r_rom_addr   <= cmd_addr;
                                r_rom_wdata  <= cmd_data;
                                r_state      <= SETUP;
                            end
                            OP_ROM_RD: begin
                                r_rom_select <= 1'b1;
                                r_rom_addr   <= cmd_addr;
                                r_state      <= SETUP;
                            end
                            OP_RF_RD: begin
                                r_rf_addr <= cmd_addr[4:0];
                                r_state   <= SETUP;
                            end
                            OP_PC_RD: r_state <= SETUP;
                            OP_CLKSEL: begin
                                r_clk_select <= cmd_data[0];
                                r_state      <= SETUP;
                            end
                            default: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= '0;
                                r_state     <= RESP;
                            end
                        endcase
                    end
                end
                CRST: begin
                    if (w_tmr_done) begin
                        r_rst_host  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= RESP;
                    end
                end
                SETUP: begin
                    if (r_op == OP_ROM_WR) begin
                        r_rom_we <= 1'b1;
                        r_state  <= WE;
                    end else if (r_op == OP_CLKSEL) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {31'd0, r_clk_select};
                        r_state     <= RESP;
                    end else begin
                        r_state <= SETTLE;
                    end
                end
                WE: begin
                    r_rom_we     <= 1'b0;
                    r_rom_select <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_data   <= r_rom_wdata;
                    r_state      <= RESP;
                end
                SETTLE: begin
                    if (w_tmr_done) begin
                        r_rom_select <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                        case (r_op)
                            OP_ROM_RD: r_rsp_data <= stat_reg6;
                            OP_RF_RD:  r_rsp_data <= stat_reg7;
                            default:   r_rsp_data <= stat_reg5;
                        endcase
                    end
                end
                CLK_HI: begin
                    if (w_tmr_done) begin
                        r_clk_host <= 1'b0;
                        r_state    <= CLK_LO;
                    end
                end
                CLK_LO: begin
                    if (w_tmr_done) begin
                        if (w_last_step) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= stat_reg5;
                            r_state     <= RESP;
                        end else begin
                            r_clk_host <= 1'b1;
                            r_state    <= CLK_HI;
`ifdef HOST_DBG_SEQ_MULTISTEP_EN
                            r_steps_left <= r_steps_left - 32'd1;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Held low through reset so no command is taken before the first idle cycle.
    assign cmd_ready = (r_state == IDLE) && rst_n;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    always_comb begin
        ctrl_reg0 = '0;
        ctrl_reg0[c_reg0_rst_bit] = r_rst_host;
        ctrl_reg0[c_reg0_clk_bit] = r_clk_host;
        ctrl_reg0[c_reg0_sel_bit] = r_clk_select;
        ctrl_reg1 = {27'd0, r_rf_addr};
        ctrl_reg2 = '0;
        ctrl_reg2[c_reg2_we_bit]        = r_rom_we;
        ctrl_reg2[c_reg2_addr_lsb +: 6] = r_rom_addr;
        ctrl_reg2[c_reg2_sel_bit]       = r_rom_select;
        ctrl_reg3 = r_rom_wdata;
        ctrl_reg4 = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_host_dbg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_host_dbg_sequencer                                                      |
// | Scoreboard bench for host_dbg_sequencer (honours HOST_DBG_SEQ_MULTISTEP_EN)|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_host_dbg_sequencer;
    import host_dbg_sequencer_pkg::*;

    localparam int HOLD   = 4;
    localparam int SETTLE = 2;
    localparam int RSTC   = 8;
`ifdef HOST_DBG_SEQ_MULTISTEP_EN
    localparam bit c_multistep = 1'b1;
`else
    localparam bit c_multistep = 1'b0;
`endif

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] ctrl_reg0, ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4;
    logic [31:0] stat_reg5, stat_reg6, stat_reg7;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    host_dbg_sequencer #(
        .HOLD_CYC   (HOLD),
        .SETTLE_CYC (SETTLE),
        .RST_CYC    (RSTC)
    ) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ctrl_reg0 (ctrl_reg0),
        .ctrl_reg1 (ctrl_reg1),
        .ctrl_reg2 (ctrl_reg2),
        .ctrl_reg3 (ctrl_reg3),
        .ctrl_reg4 (ctrl_reg4),
        .stat_reg5 (stat_reg5),
        .stat_reg6 (stat_reg6),
        .stat_reg7 (stat_reg7)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation.
    always @(negedge sysclk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_data", rsp_data, mon_e.data);
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
            end
        end
    end

    // Offer a command at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [5:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                        input bit hold);
        int n = 0;
        int acc = 0;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        sb_q.push_back('{exp_d, exp_e, exp_lat, cyc});
        @(negedge sysclk);
        if (hold) begin
            n = 0;
            while (!rsp_valid && n < 1000) begin
                if (cmd_ready) acc++;
                @(negedge sysclk);
                n++;
            end
            check("busy_extra_accept", 32'(acc), 32'd0);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(negedge sysclk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("rsp_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge sysclk);
    endtask

    // Profile one ctrl_reg0 bit from now until the response cycle.
    task automatic watch(input int b, output int hi, output int rises, output int max_run);
        int   run = 0;
        int   n = 0;
        logic prev = 1'b0;
        hi = 0; rises = 0; max_run = 0;
        while (n < 1000) begin
            if (ctrl_reg0[b]) begin
                hi++;
                run++;
                if (!prev) rises++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            prev = ctrl_reg0[b];
            if (rsp_valid) break;
            @(negedge sysclk);
            n++;
        end
        if (n >= 1000) check("watch_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, rises, max_run, n_steps, a;
        logic [31:0] s0, s1, s2, s3;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        stat_reg5 = 32'h0000_0100; stat_reg6 = '0; stat_reg7 = '0;
        repeat (3) @(negedge sysclk);
        check("ready_in_reset", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge sysclk);
        check("ready_after_rel", 32'(cmd_ready), 32'd1);
        check("rst_reg0", ctrl_reg0, 32'd0);
        check("rst_reg1", ctrl_reg1, 32'd0);
        check("rst_reg2", ctrl_reg2, 32'd0);
        check("rst_reg3", ctrl_reg3, 32'd0);
        check("rst_reg4", ctrl_reg4, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);

        send(OP_ROM_WR, 6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
        check("wr_setup_reg2", ctrl_reg2, 32'h8A);
        check("wr_reg3", ctrl_reg3, 32'hDEAD_BEEF);
        @(negedge sysclk);
        check("wr_we_reg2", ctrl_reg2, 32'h8B);
        @(negedge sysclk);
        check("wr_resp_reg2", ctrl_reg2, 32'h0A);
        drain();

        stat_reg6 = 32'hCAFE_F00D;
        send(OP_ROM_RD, 6'h2A, 32'd0, 32'hCAFE_F00D, 1'b0, SETTLE + 2, 1'b0);
        check("rd_setup_reg2", ctrl_reg2, 32'hD4);
        drain();
        check("rd_after_reg2", ctrl_reg2, 32'h54);
        check("rd_after_reg3", ctrl_reg3, 32'hDEAD_BEEF);

        stat_reg7 = 32'h0000_1234;
        send(OP_RF_RD, 6'h3F, 32'd0, 32'h0000_1234, 1'b0, SETTLE + 2, 1'b0);
        check("rf_reg1", ctrl_reg1, 32'h1F);
        drain();

        for (int i = 0; i < 3; i++) begin
            a = int'($urandom_range(0, 30));
            stat_reg7 = $urandom;
            send(OP_RF_RD, 6'(a), 32'd0, stat_reg7, 1'b0, SETTLE + 2, 1'b0);
            check("rf_rand_reg1", ctrl_reg1, 32'(a));
            drain();
        end

        stat_reg5 = 32'h0000_0100;
        send(OP_PC_RD, 6'd0, 32'd0, 32'h0000_0100, 1'b0, SETTLE + 2, 1'b0);
        drain();

        send(OP_CORE_RST, 6'd0, 32'd0, 32'd0, 1'b0, RSTC + 1, 1'b0);
        watch(0, hi, rises, max_run);
        check("crst_high_cycles", 32'(hi), 32'(RSTC));
        check("crst_pulses", 32'(rises), 32'd1);
        drain();

        n_steps = c_multistep ? 3 : 1;
        stat_reg5 = 32'h0000_0ABC;
        send(OP_STEP, 6'd0, 32'd3, 32'h0000_0ABC, 1'b0, n_steps * 2 * HOLD + 1, 1'b0);
        watch(1, hi, rises, max_run);
        check("step_pulses", 32'(rises), 32'(n_steps));
        check("step_high_cycles", 32'(hi), 32'(n_steps * HOLD));
        check("step_pulse_width", 32'(max_run), 32'(HOLD));
        drain();

        n_steps = c_multistep ? 0 : 1;
        stat_reg5 = 32'h0000_0055;
        send(OP_STEP, 6'd0, 32'd0, 32'h0000_0055, 1'b0, n_steps * 2 * HOLD + 1, 1'b0);
        watch(1, hi, rises, max_run);
        check("step0_pulses", 32'(rises), 32'(n_steps));
        drain();

        send(OP_CLKSEL, 6'd0, 32'd1, 32'd1, 1'b0, 2, 1'b0);
        check("clksel_bit", 32'(ctrl_reg0[2]), 32'd1);
        drain();

        s0 = ctrl_reg0; s1 = ctrl_reg1; s2 = ctrl_reg2; s3 = ctrl_reg3;
        send(3'd7, 6'h3F, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1);
        drain();
        check("rsvd_reg0", ctrl_reg0, s0);
        check("rsvd_reg1", ctrl_reg1, s1);
        check("rsvd_reg2", ctrl_reg2, s2);
        check("rsvd_reg3", ctrl_reg3, s3);

        stat_reg7 = 32'h0BAD_F00D;
        send(OP_RF_RD, 6'd3, 32'd0, 32'h0BAD_F00D, 1'b0, SETTLE + 2, 1'b1);
        drain();

        send(OP_STEP, 6'd0, 32'd3, 32'd0, 1'b0, 1, 1'b0);
        check("mid_step_clk_hi", 32'(ctrl_reg0[1]), 32'd1);
        @(negedge sysclk);
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge sysclk);
        check("rst_mid_reg0", ctrl_reg0, 32'd0);
        check("rst_mid_reg1", ctrl_reg1, 32'd0);
        check("rst_mid_reg3", ctrl_reg3, 32'd0);
        check("rst_mid_rsp_data", rsp_data, 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge sysclk);
        check("rst_mid_ready_rel", 32'(cmd_ready), 32'd1);
        repeat (40) @(negedge sysclk);
        check("rst_mid_no_resume", ctrl_reg0, 32'd0);

        stat_reg5 = 32'h1234_5678;
        send(OP_PC_RD, 6'd0, 32'd0, 32'h1234_5678, 1'b0, SETTLE + 2, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
